rv_sram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the FPGA SRAM driver (`rv_sram_driver`). It shares the single 16-bit external SRAM between the load/store unit (port 0) and instruction fetch (port 1). It accepts one request at a time, holds the address, byte enables and write data stable for the whole multi-cycle SRAM access, and routes the response to the owning port. A watchdog ends stalled accesses with an error response.

---
 rtl/rv_sram_arbiter.sv | 128 ++++++++++++
 tb/tb_rv_sram_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of rv_sram_driver.
// One access in flight; request fields held on mem_* from grant to next grant.
module rv_sram_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,
    output logic              m1_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    // state  | meaning
    // IDLE   | no access in flight; arbitrate and latch the winner's fields
    // ISSUE  | mem_req_o pulse seen by the driver; clear the watchdog
    // WAIT   | waiting for mem_rvalid_i or watchdog expiry
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          state_q;
    logic            last_q;
    logic            owner_q;
    logic [7:0]      cnt_q;
    logic            any_req;
    logic            sel;
    logic            cmpl;
    logic            cmpl_err;
    logic [XLEN-1:0] cmpl_data;

    // On a tie the port that was not granted last wins.
    always_comb begin
        any_req   = m0_req_i | m1_req_i;
        sel       = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
        cmpl      = mem_rvalid_i | (cnt_q == TO_LAST);
        cmpl_err  = ~mem_rvalid_i;
        cmpl_data = mem_rvalid_i ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            m0_gnt_o    <= 1'b0;
            m1_gnt_o    <= 1'b0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
            m0_err_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            m0_gnt_o    <= 1'b0;
            m1_gnt_o    <= 1'b0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            mem_req_o   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q     <= sel;
                        last_q      <= sel;
                        mem_req_o   <= 1'b1;
                        m0_gnt_o    <= ~sel;
                        m1_gnt_o    <= sel;
                        mem_we_o    <= sel ? m1_we_i    : m0_we_i;
                        mem_be_o    <= sel ? m1_be_i    : m0_be_i;
                        mem_addr_o  <= sel ? m1_addr_i  : m0_addr_i;
                        mem_wdata_o <= sel ? m1_wdata_i : m0_wdata_i;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cmpl) begin
                        if (owner_q) begin
                            m1_rvalid_o <= 1'b1;
                            m1_rdata_o  <= cmpl_data;
                            m1_err_o    <= cmpl_err;
                        end else begin
                            m0_rvalid_o <= 1'b1;
                            m0_rdata_o  <= cmpl_data;
                            m0_err_o    <= cmpl_err;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_sram_arbiter.sv
// Directed bench for rv_sram_arbiter: arbitration order, response routing,
// watchdog expiry, late-response drop, same-cycle tie and mid-access reset.
module tb_rv_sram_arbiter;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
    logic [3:0]  m0_be_i = '0;
    logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m1_be_i = '0;
    logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd1 = '0;

    rv_sram_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " m0_gnt"}, 32'(m0_gnt_o), 32'd0);
        check({tag, " m1_gnt"}, 32'(m1_gnt_o), 32'd0);
        check({tag, " m0_rvalid"}, 32'(m0_rvalid_o), 32'd0);
        check({tag, " m1_rvalid"}, 32'(m1_rvalid_o), 32'd0);
        check({tag, " mem_req"}, 32'(mem_req_o), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_idle_outputs(tag);
        check({tag, " m0_err"}, 32'(m0_err_o), 32'd0);
        check({tag, " m1_err"}, 32'(m1_err_o), 32'd0);
        check({tag, " m0_rdata"}, m0_rdata_o, 32'd0);
        check({tag, " m1_rdata"}, m1_rdata_o, 32'd0);
        check({tag, " mem_we"}, 32'(mem_we_o), 32'd0);
        check({tag, " mem_be"}, 32'(mem_be_o), 32'd0);
        check({tag, " mem_addr"}, mem_addr_o, 32'd0);
        check({tag, " mem_wdata"}, mem_wdata_o, 32'd0);
    endtask

    // Requests must already be driven; next edge is expected to grant `port`.
    // Driver model answers `dly` cycles after the ISSUE edge with `rd`.
    task automatic run_txn(input string tag, input bit port, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int dly);
        step();
        check({tag, " gnt owner"}, 32'(port ? m1_gnt_o : m0_gnt_o), 32'd1);
        check({tag, " gnt other"}, 32'(port ? m0_gnt_o : m1_gnt_o), 32'd0);
        check({tag, " mem_req at grant"}, 32'(mem_req_o), 32'd1);
        check({tag, " mem_addr at grant"}, mem_addr_o, addr);
        check({tag, " mem_wdata at grant"}, mem_wdata_o, wd);
        for (int i = 0; i < dly; i++) begin
            step();
            check_idle_outputs({tag, " wait"});
            check({tag, " mem_addr held"}, mem_addr_o, addr);
            check({tag, " mem_wdata held"}, mem_wdata_o, wd);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd;
        step();
        mem_rvalid_i = 1'b0;
        if (port) exp_rd1 = rd; else exp_rd0 = rd;
        check({tag, " rvalid owner"}, 32'(port ? m1_rvalid_o : m0_rvalid_o), 32'd1);
        check({tag, " rvalid other"}, 32'(port ? m0_rvalid_o : m1_rvalid_o), 32'd0);
        check({tag, " err owner"}, 32'(port ? m1_err_o : m0_err_o), 32'd0);
        check({tag, " m0_rdata"}, m0_rdata_o, exp_rd0);
        check({tag, " m1_rdata"}, m1_rdata_o, exp_rd1);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        arstn_i = 1'b1;

        // Tie after reset, both held: order 0,1,0,1.
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_addr_i = 32'h200; m0_wdata_i = 32'hA0A0A0A0;
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_addr_i = 32'h300; m1_wdata_i = 32'hB0B0B0B0;
        run_txn("rr0", 1'b0, 32'h200, 32'hA0A0A0A0, 32'h11111111, 1);
        run_txn("rr1", 1'b1, 32'h300, 32'hB0B0B0B0, 32'h22222222, 1);
        run_txn("rr2", 1'b0, 32'h200, 32'hA0A0A0A0, 32'h11111111, 1);
        run_txn("rr3", 1'b1, 32'h300, 32'hB0B0B0B0, 32'h22222222, 1);
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        step();
        check_idle_outputs("rr idle");

        // Port 0 lone write.
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_be_i = 4'hF; m0_addr_i = 32'h100; m0_wdata_i = 32'hDEADBEEF;
        step();
        check("wr gnt0", 32'(m0_gnt_o), 32'd1);
        check("wr gnt1", 32'(m1_gnt_o), 32'd0);
        check("wr mem_we", 32'(mem_we_o), 32'd1);
        check("wr mem_be", 32'(mem_be_o), 32'hF);
        check("wr mem_addr", mem_addr_o, 32'h100);
        check("wr mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        m0_req_i = 1'b0; m0_addr_i = 32'h0; m0_wdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("wr wait");
            check("wr addr held", mem_addr_o, 32'h100);
            check("wr wdata held", mem_wdata_o, 32'hDEADBEEF);
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
        step();
        mem_rvalid_i = 1'b0;
        exp_rd0 = 32'h5555AAAA;
        check("wr rvalid0", 32'(m0_rvalid_o), 32'd1);
        check("wr rvalid1", 32'(m1_rvalid_o), 32'd0);
        check("wr err0", 32'(m0_err_o), 32'd0);
        check("wr m1_rdata untouched", m1_rdata_o, exp_rd1);
        step();
        check_idle_outputs("wr after");
        check("wr addr after", mem_addr_o, 32'h100);

        // Port 1 read.
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_addr_i = 32'h40; m1_wdata_i = 32'h0;
        run_txn("rd1", 1'b1, 32'h40, 32'h0, 32'hCAFEF00D, 3);
        m1_req_i = 1'b0;
        step();
        check_idle_outputs("rd1 after");

        // Watchdog expiry on port 0, then a late response is ignored.
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h80;
        step();
        check("to gnt0", 32'(m0_gnt_o), 32'd1);
        m0_req_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check_idle_outputs("to wait");
        end
        step();
        exp_rd0 = 32'h0;
        check("to rvalid0", 32'(m0_rvalid_o), 32'd1);
        check("to err0", 32'(m0_err_o), 32'd1);
        check("to rdata0", m0_rdata_o, 32'h0);
        check("to rvalid1", 32'(m1_rvalid_o), 32'd0);
        step();
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99999999;
        step();
        mem_rvalid_i = 1'b0;
        check_idle_outputs("late rsp");
        check("late rdata0", m0_rdata_o, 32'h0);
        check("late err0 held", 32'(m0_err_o), 32'd1);
        step();
        check_idle_outputs("late rsp +1");

        // mem_rvalid_i on the watchdog's last cycle wins.
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h44;
        step();
        check("tie gnt1", 32'(m1_gnt_o), 32'd1);
        m1_req_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check_idle_outputs("tie wait");
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77771234;
        step();
        mem_rvalid_i = 1'b0;
        check("tie rvalid1", 32'(m1_rvalid_o), 32'd1);
        check("tie err1", 32'(m1_err_o), 32'd0);
        check("tie rdata1", m1_rdata_o, 32'h77771234);
        check("tie m0 err untouched", 32'(m0_err_o), 32'd1);

        // Reset while in WAIT.
        step();
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_be_i = 4'b0011; m1_addr_i = 32'h60; m1_wdata_i = 32'h1234;
        step();
        check("rst gnt1", 32'(m1_gnt_o), 32'd1);
        m1_req_i = 1'b0;
        step();
        step();
        arstn_i = 1'b0;
        #1;
        check_reset_values("midreset");
        #1;
        arstn_i = 1'b1;
        exp_rd0 = 32'h0; exp_rd1 = 32'h0;
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_addr_i = 32'h64; m1_wdata_i = 32'h0;
        run_txn("post rst", 1'b1, 32'h64, 32'h0, 32'hBEEF0001, 2);
        m1_req_i = 1'b0;
        step();
        check_idle_outputs("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
